// File: rtl/seq_divider.sv
// seq_divider: multi-cycle unsigned restoring divider.
// Divides a 2*SIZE_DIV-bit dividend by a SIZE_DIV-bit divisor, one quotient
// bit per clock, with a start/busy/done handshake. A zero divisor finishes
// immediately with dbz set, quotient all ones and remainder = low dividend bits.
module seq_divider #(
    parameter int SIZE_DIV = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [2*SIZE_DIV-1:0]   dividend,
    input  logic [SIZE_DIV-1:0]     divisor,
    output logic                    busy,
    output logic                    done,
    output logic [2*SIZE_DIV-1:0]   quotient,
    output logic [SIZE_DIV-1:0]     remainder,
    output logic                    dbz
);

    localparam int QW = 2 * SIZE_DIV;
    localparam int CW = $clog2(QW + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [CW-1:0]          r_cnt;
    logic [SIZE_DIV-1:0]    r_prem;
    logic [QW-1:0]          r_shreg;
    logic [SIZE_DIV-1:0]    r_div;
    logic [QW-1:0]          r_quot;
    logic [SIZE_DIV-1:0]    r_rem;
    logic                   r_dbz;

    logic                   w_accept;
    logic                   w_div_zero;
    logic                   w_last;
    logic [SIZE_DIV:0]      w_trial;
    logic                   w_ge;
    logic [SIZE_DIV-1:0]    w_prem_next;
    logic [QW-1:0]          w_shreg_next;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    // The stored partial remainder is always < divisor, so SIZE_DIV bits hold
    // it; only the shifted trial value needs the extra bit.
    always_comb begin
        w_trial      = {r_prem, r_shreg[QW-1]};
        w_ge         = (w_trial >= {1'b0, r_div});
        w_prem_next  = SIZE_DIV'(w_ge ? (w_trial - {1'b0, r_div}) : w_trial);
        w_shreg_next = {r_shreg[QW-2:0], w_ge};
        w_accept     = start && (r_state != S_RUN);
        w_div_zero   = (divisor == '0);
        w_last       = (r_cnt == CW'(1));
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                done = (r_state == S_DONE);
                if (w_accept) begin
                    w_state_next = w_div_zero ? S_DONE : S_RUN;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Operand latch, iteration datapath and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_prem  <= '0;
            r_shreg <= '0;
            r_div   <= '0;
            r_quot  <= '0;
            r_rem   <= '0;
            r_dbz   <= 1'b0;
        end else if (w_accept) begin
            r_div   <= divisor;
            r_shreg <= dividend;
            r_prem  <= '0;
            r_cnt   <= CW'(QW);
            if (w_div_zero) begin
                r_quot <= '1;
                r_rem  <= dividend[SIZE_DIV-1:0];
                r_dbz  <= 1'b1;
            end
        end else if (r_state == S_RUN) begin
            r_prem  <= w_prem_next;
            r_shreg <= w_shreg_next;
            r_cnt   <= r_cnt - CW'(1);
            if (w_last) begin
                r_quot <= w_shreg_next;
                r_rem  <= w_prem_next;
                r_dbz  <= 1'b0;
            end
        end
    end

    // Result outputs.
    always_comb begin
        quotient  = r_quot;
        remainder = r_rem;
        dbz       = r_dbz;
    end

endmodule

// File: tb/tb_seq_divider.sv
// Directed and random checks for seq_divider with SIZE_DIV=6.
module tb_seq_divider;

    localparam int S = 6;

    logic           clk;
    logic           rst;
    logic           start;
    logic [2*S-1:0] dividend;
    logic [S-1:0]   divisor;
    logic           busy;
    logic           done;
    logic [2*S-1:0] quotient;
    logic [S-1:0]   remainder;
    logic           dbz;

    int checks   = 0;
    int failures = 0;

    seq_divider #(.SIZE_DIV(S)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .dbz       (dbz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Pulse start for one edge (E0); returns #1 after E0.
    task automatic start_op(input logic [2*S-1:0] dd, input logic [S-1:0] dv);
        dividend = dd;
        divisor  = dv;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
    endtask

    // Count edges until done is seen, starting from lat0 edges after E0.
    // Results must hold steady while waiting.
    task automatic wait_done(input int lat0, output int lat, output int nbusy);
        logic [2*S-1:0] q0;
        logic [S-1:0]   r0;
        q0    = quotient;
        r0    = remainder;
        lat   = lat0;
        nbusy = 0;
        while (!done && lat < 40) begin
            if (busy) nbusy++;
            if (quotient !== q0 || remainder !== r0) begin
                chk("hold_during_run", {20'd0, quotient}, {20'd0, q0});
                q0 = quotient;
                r0 = remainder;
            end
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    int lat;
    int nb;
    int ndone;
    logic [2*S-1:0] rdd;
    logic [S-1:0]   rdv;

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_dbz",  32'(dbz), 0);
        chk("rst_q",    32'(quotient), 0);
        chk("rst_r",    32'(remainder), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 1200 / 20
        start_op(12'd1200, 6'd20);
        wait_done(0, lat, nb);
        chk("t1_lat",  lat, 12);
        chk("t1_busy", nb, 12);
        chk("t1_q",    32'(quotient), 60);
        chk("t1_r",    32'(remainder), 0);
        chk("t1_dbz",  32'(dbz), 0);
        @(posedge clk);
        #1;
        chk("t1_done_pulse", 32'(done), 0);
        chk("t1_idle_busy",  32'(busy), 0);

        // Directed vectors
        start_op(12'd2500, 6'd47);
        wait_done(0, lat, nb);
        chk("t2a_lat", lat, 12);
        chk("t2a_q", 32'(quotient), 53);
        chk("t2a_r", 32'(remainder), 9);
        @(posedge clk);
        #1;
        start_op(12'd4095, 6'd63);
        wait_done(0, lat, nb);
        chk("t2b_q", 32'(quotient), 65);
        chk("t2b_r", 32'(remainder), 0);
        @(posedge clk);
        #1;
        start_op(12'd3, 6'd10);
        wait_done(0, lat, nb);
        chk("t2c_q", 32'(quotient), 0);
        chk("t2c_r", 32'(remainder), 3);
        @(posedge clk);
        #1;

        // Divide by zero
        start_op(12'd777, 6'd0);
        wait_done(0, lat, nb);
        chk("t3_lat",  lat, 0);
        chk("t3_busy", 32'(busy), 0);
        chk("t3_dbz",  32'(dbz), 1);
        chk("t3_q",    32'(quotient), 4095);
        chk("t3_r",    32'(remainder), 9);
        @(posedge clk);
        #1;
        chk("t3_done_pulse", 32'(done), 0);
        chk("t3_dbz_held",   32'(dbz), 1);

        // start mid-RUN is ignored
        start_op(12'd1000, 6'd7);
        repeat (5) @(posedge clk);
        #1;
        dividend = 12'd50;
        divisor  = 6'd3;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        chk("t4_dbz_held_run", 32'(dbz), 1);
        wait_done(6, lat, nb);
        chk("t4_lat", lat, 12);
        chk("t4_q",   32'(quotient), 142);
        chk("t4_r",   32'(remainder), 6);
        chk("t4_dbz", 32'(dbz), 0);

        // Back-to-back accept during DONE
        dividend = 12'd100;
        divisor  = 6'd9;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        chk("t4b_busy", 32'(busy), 1);
        chk("t4b_done", 32'(done), 0);
        wait_done(0, lat, nb);
        chk("t4b_lat", lat, 12);
        chk("t4b_q",   32'(quotient), 11);
        chk("t4b_r",   32'(remainder), 1);
        @(posedge clk);
        #1;

        // Asynchronous reset mid-division
        start_op(12'd2000, 6'd13);
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("t5_busy", 32'(busy), 0);
        chk("t5_done", 32'(done), 0);
        chk("t5_q",    32'(quotient), 0);
        chk("t5_r",    32'(remainder), 0);
        chk("t5_dbz",  32'(dbz), 0);
        @(posedge clk);
        #1;
        rst   = 1'b0;
        ndone = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        chk("t5_no_done", ndone, 0);
        start_op(12'd2000, 6'd13);
        wait_done(0, lat, nb);
        chk("t5_lat", lat, 12);
        chk("t5_q2",  32'(quotient), 153);
        chk("t5_r2",  32'(remainder), 11);
        @(posedge clk);
        #1;

        // Random operands
        for (int i = 0; i < 500; i++) begin
            rdd = 12'($urandom_range(0, 4095));
            rdv = 6'($urandom_range(1, 63));
            start_op(rdd, rdv);
            wait_done(0, lat, nb);
            chk("rand_lat", lat, 12);
            chk("rand_eq", 32'(quotient) * 32'(rdv) + 32'(remainder), 32'(rdd));
            chk("rand_rlt", 32'(remainder < rdv), 1);
            if ((i % 2) == 0) begin
                @(posedge clk);
                #1;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
